// File: rtl/irq_sched_if.sv
// CPU-side handshake bundle of the interrupt scheduler: ISR redirect request,
// acceptance with the return PC, ERET, and the current top-of-stack EPC.
interface irq_sched_if #(
    parameter int NBIT_IRQ     = 2,
    parameter int IM_ADDR_NBIT = 10
);
    logic                    irq_req;
    logic [NBIT_IRQ-1:0]     irq_num;
    logic                    irq_ack;
    logic [IM_ADDR_NBIT-1:0] ret_pc;
    logic                    eret;
    logic [IM_ADDR_NBIT-1:0] epc;

    // CPU pipeline side
    modport master (
        input  irq_req,
        input  irq_num,
        input  epc,
        output irq_ack,
        output ret_pc,
        output eret
    );

    // Scheduler side
    modport slave (
        output irq_req,
        output irq_num,
        output epc,
        input  irq_ack,
        input  ret_pc,
        input  eret
    );
endinterface

// File: rtl/irq_sched.sv
// Interrupt scheduler: captures request edges into a pending register, applies
// the global enable and per-line mask, selects the highest-priority line that
// may preempt the current service level, and keeps a stack of return PCs for
// nested ERETs. Line 0 has the highest priority.
module irq_sched #(
    parameter int NIRQ         = 3,
    parameter int NBIT_IRQ     = 2,
    parameter int IM_ADDR_NBIT = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NIRQ-1:0]   irq_src,
    input  logic              ie_set,
    input  logic              ie_clr,
    input  logic              mask_we,
    input  logic [NIRQ-1:0]   mask_wdata,
    irq_sched_if.slave        cpu,
    output logic              ie,
    output logic [NIRQ-1:0]   pending,
    output logic [NIRQ-1:0]   in_svc
);

    // Index width able to hold 0..NIRQ, where NIRQ means "no line".
    localparam int IDX_W = $clog2(NIRQ + 1);
    // Stack pointer width able to hold 0..NIRQ entries.
    localparam int SP_W  = $clog2(NIRQ + 1);

    // Lowest set index of a line vector, or NIRQ when the vector is empty.
    function automatic logic [IDX_W-1:0] first_set(input logic [NIRQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = IDX_W'(NIRQ);
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot decode of a line index; an out-of-range index gives all zeros.
    function automatic logic [NIRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NIRQ-1:0] oh;
        oh = {NIRQ{1'b0}};
        for (int i = 0; i < NIRQ; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Architectural state
    logic                    ie_r;
    logic [NIRQ-1:0]         mask_r;
    logic [NIRQ-1:0]         pending_r;
    logic [NIRQ-1:0]         in_svc_r;
    logic [NIRQ-1:0]         src_q_r;
    logic [SP_W-1:0]         sp_r;
    logic [IM_ADDR_NBIT-1:0] stack_r [NIRQ];

    // Combinational decisions
    logic [NIRQ-1:0]         rise_s;
    logic [NIRQ-1:0]         elig_s;
    logic [IDX_W-1:0]        cur_s;
    logic [NIRQ-1:0]         above_cur_s;
    logic [IDX_W-1:0]        cand_s;
    logic                    cand_vld_s;
    logic                    stack_room_s;
    logic                    irq_req_s;
    logic                    accept_s;
    logic                    pop_s;
    logic [NIRQ-1:0]         cand_oh_s;
    logic [IM_ADDR_NBIT-1:0] epc_s;

    // Next-state values
    logic                    ie_nxt_s;
    logic [NIRQ-1:0]         pending_nxt_s;
    logic [NIRQ-1:0]         in_svc_nxt_s;
    logic [SP_W-1:0]         sp_nxt_s;

    // Edge detect and eligibility: only lines of strictly higher priority than
    // the line currently in service may be selected.
    always_comb begin
        rise_s = irq_src & ~src_q_r;
        elig_s = pending_r & mask_r & ~in_svc_r;
        cur_s  = first_set(in_svc_r);
        above_cur_s = {NIRQ{1'b0}};
        for (int i = 0; i < NIRQ; i++) begin
            if (IDX_W'(i) < cur_s) begin
                above_cur_s[i] = 1'b1;
            end else begin
                above_cur_s[i] = 1'b0;
            end
        end
        cand_s     = first_set(elig_s & above_cur_s);
        cand_vld_s = (cand_s != IDX_W'(NIRQ));
        cand_oh_s  = onehot(cand_s);
    end

    // Redirect request and the two stack-changing events; ERET masks the
    // request so a same-cycle ack can never be accepted alongside a pop.
    always_comb begin
        stack_room_s = (sp_r < SP_W'(NIRQ));
        irq_req_s    = ie_r & cand_vld_s & ~cpu.eret & stack_room_s;
        accept_s     = cpu.irq_ack & irq_req_s;
        pop_s        = cpu.eret & (sp_r != {SP_W{1'b0}});
    end

    // Top-of-stack read; zero while the stack is empty.
    always_comb begin
        epc_s = {IM_ADDR_NBIT{1'b0}};
        for (int i = 0; i < NIRQ; i++) begin
            if (sp_r == SP_W'(i + 1)) begin
                epc_s = stack_r[i];
            end else begin
                epc_s = epc_s;
            end
        end
    end

    // Next-state computation for enable, pending, in-service and stack pointer.
    // Enable priority: accept (0) > eret (1) > ie_clr (0) > ie_set (1).
    always_comb begin
        ie_nxt_s      = ie_r;
        pending_nxt_s = (pending_r & ~(accept_s ? cand_oh_s : {NIRQ{1'b0}})) | rise_s;
        in_svc_nxt_s  = in_svc_r;
        sp_nxt_s      = sp_r;
        if (accept_s) begin
            ie_nxt_s     = 1'b0;
            in_svc_nxt_s = in_svc_r | cand_oh_s;
            sp_nxt_s     = sp_r + SP_W'(1);
        end else if (pop_s) begin
            ie_nxt_s     = 1'b1;
            // Clearing the lowest set bit retires the innermost (highest
            // priority) nesting level.
            in_svc_nxt_s = in_svc_r & (in_svc_r - {{(NIRQ-1){1'b0}}, 1'b1});
            sp_nxt_s     = sp_r - SP_W'(1);
        end else if (ie_clr) begin
            ie_nxt_s = 1'b0;
        end else if (ie_set) begin
            ie_nxt_s = 1'b1;
        end else begin
            ie_nxt_s = ie_r;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_r      <= 1'b0;
            mask_r    <= {NIRQ{1'b1}};
            pending_r <= {NIRQ{1'b0}};
            in_svc_r  <= {NIRQ{1'b0}};
            src_q_r   <= {NIRQ{1'b0}};
            sp_r      <= {SP_W{1'b0}};
        end else begin
            ie_r      <= ie_nxt_s;
            pending_r <= pending_nxt_s;
            in_svc_r  <= in_svc_nxt_s;
            src_q_r   <= irq_src;
            sp_r      <= sp_nxt_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Return-PC stack: push at the current stack pointer on an accepted ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NIRQ; i++) begin
                stack_r[i] <= {IM_ADDR_NBIT{1'b0}};
            end
        end else begin
            for (int i = 0; i < NIRQ; i++) begin
                if (accept_s && (sp_r == SP_W'(i))) begin
                    stack_r[i] <= cpu.ret_pc;
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
        end
    end

    assign cpu.irq_req = irq_req_s;
    assign cpu.irq_num = irq_req_s ? NBIT_IRQ'(cand_s) : {NBIT_IRQ{1'b0}};
    assign cpu.epc     = epc_s;
    assign ie          = ie_r;
    assign pending     = pending_r;
    assign in_svc      = in_svc_r;

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: directed scenarios followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_irq_sched;

    localparam int NIRQ = 3;
    localparam int NB   = 2;
    localparam int AW   = 10;

    logic            clk;
    logic            rst_n;
    logic [NIRQ-1:0] irq_src;
    logic            ie_set;
    logic            ie_clr;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic            ie;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] in_svc;

    irq_sched_if #(.NBIT_IRQ(NB), .IM_ADDR_NBIT(AW)) bus ();

    irq_sched #(.NIRQ(NIRQ), .NBIT_IRQ(NB), .IM_ADDR_NBIT(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .ie_set     (ie_set),
        .ie_clr     (ie_clr),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .cpu        (bus),
        .ie         (ie),
        .pending    (pending),
        .in_svc     (in_svc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit              m_ie;
    bit [NIRQ-1:0]   m_mask;
    bit [NIRQ-1:0]   m_pend;
    bit [NIRQ-1:0]   m_svc;
    bit [NIRQ-1:0]   m_srcq;
    logic [AW-1:0]   m_stack[$];

    function automatic void m_reset();
        m_ie = 1'b0;
        m_mask = '1;
        m_pend = '0;
        m_svc = '0;
        m_srcq = '0;
        m_stack.delete();
    endfunction

    // Highest-priority line allowed to preempt current service, or -1.
    function automatic int m_cand();
        int cur = NIRQ;
        for (int i = NIRQ - 1; i >= 0; i--) if (m_svc[i]) cur = i;
        for (int i = 0; i < cur; i++)
            if (m_pend[i] && m_mask[i] && !m_svc[i]) return i;
        return -1;
    endfunction

    function automatic bit m_req();
        return m_ie && (m_cand() >= 0) && !bus.eret && (m_stack.size() < NIRQ);
    endfunction

    function automatic void m_step();
        bit acc;
        int c;
        c   = m_cand();
        acc = bus.irq_ack && m_req();
        for (int i = 0; i < NIRQ; i++) begin
            if (acc && c == i) m_pend[i] = 1'b0;
            if (irq_src[i] && !m_srcq[i]) m_pend[i] = 1'b1;
        end
        if (acc) begin
            m_stack.push_back(bus.ret_pc);
            m_svc[c] = 1'b1;
            m_ie = 1'b0;
        end else if (bus.eret && m_stack.size() > 0) begin
            void'(m_stack.pop_back());
            for (int i = 0; i < NIRQ; i++)
                if (m_svc[i]) begin m_svc[i] = 1'b0; break; end
            m_ie = 1'b1;
        end else if (ie_clr) begin
            m_ie = 1'b0;
        end else if (ie_set) begin
            m_ie = 1'b1;
        end
        if (mask_we) m_mask = mask_wdata;
        m_srcq = irq_src;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [NIRQ-1:0] src, input logic s, input logic c,
                         input logic mw, input logic [NIRQ-1:0] md, input logic ack,
                         input logic [AW-1:0] rpc, input logic er);
        irq_src = src; ie_set = s; ie_clr = c; mask_we = mw; mask_wdata = md;
        bus.irq_ack = ack; bus.ret_pc = rpc; bus.eret = er;
    endtask

    task automatic idle(input logic [NIRQ-1:0] src);
        drive(src, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0);
    endtask

    // Let inputs settle and compare every output against the model.
    task automatic settle();
        bit r;
        int c;
        #1;
        r = m_req();
        c = m_cand();
        check_eq("irq_req", bus.irq_req, r);
        check_eq("irq_num", bus.irq_num, r ? c : 0);
        check_eq("epc", bus.epc, m_stack.size() > 0 ? m_stack[$] : 10'h000);
        check_eq("ie", ie, m_ie);
        check_eq("pending", pending, m_pend);
        check_eq("in_svc", in_svc, m_svc);
    endtask

    task automatic advance();
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic cyc_idle(input logic [NIRQ-1:0] src);
        idle(src); settle(); advance();
    endtask

    initial begin
        rst_n = 1'b0;
        idle(3'b000);
        bus.irq_ack = 1'b0; bus.eret = 1'b0; bus.ret_pc = '0;
        m_reset();
        repeat (2) @(negedge clk);
        settle();
        check_eq("rst_mask_path", {bus.irq_req, 2'(bus.irq_num)}, 3'b000);
        rst_n = 1'b1;

        // Single line
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        cyc_idle(3'b010);
        idle(3'b000); settle();
        check_eq("sl_pend", pending, 3'b010);
        check_eq("sl_req", bus.irq_req, 1'b1);
        check_eq("sl_num", bus.irq_num, 2'd1);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h040, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("sl_ack_pend", pending, 3'b000);
        check_eq("sl_ack_svc", in_svc, 3'b010);
        check_eq("sl_ack_ie", ie, 1'b0);
        check_eq("sl_ack_epc", bus.epc, 10'h040);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b1); settle();
        check_eq("sl_eret_epc", bus.epc, 10'h040);
        advance();
        idle(3'b000); settle();
        check_eq("sl_ret_svc", in_svc, 3'b000);
        check_eq("sl_ret_ie", ie, 1'b1);
        check_eq("sl_ret_epc", bus.epc, 10'h000);
        advance();

        // Priority
        cyc_idle(3'b101);
        idle(3'b000); settle();
        check_eq("pr_num", bus.irq_num, 2'd0);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h200, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("pr_req_drop", bus.irq_req, 1'b0);
        advance();
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("pr_no_preempt", bus.irq_req, 1'b0);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b1); settle(); advance();
        idle(3'b000); settle();
        check_eq("pr_l2_req", bus.irq_req, 1'b1);
        check_eq("pr_l2_num", bus.irq_num, 2'd2);
        advance();

        // Nesting
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h100, 1'b0); settle(); advance();
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        cyc_idle(3'b010);
        idle(3'b000); settle();
        check_eq("ne_num", bus.irq_num, 2'd1);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h123, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("ne_epc", bus.epc, 10'h123);
        check_eq("ne_svc", in_svc, 3'b110);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b1); settle(); advance();
        idle(3'b000); settle();
        check_eq("ne_epc2", bus.epc, 10'h100);
        check_eq("ne_svc2", in_svc, 3'b100);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b1); settle(); advance();
        idle(3'b000); settle();
        check_eq("ne_svc3", in_svc, 3'b000);
        advance();

        // Mask
        drive(3'b000, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 10'h000, 1'b0); settle(); advance();
        cyc_idle(3'b001);
        idle(3'b000); settle();
        check_eq("mk_pend0", pending[0], 1'b1);
        check_eq("mk_noreq", bus.irq_req, 1'b0);
        advance();
        drive(3'b000, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0, 10'h000, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("mk_req", bus.irq_req, 1'b1);
        check_eq("mk_num", bus.irq_num, 2'd0);
        advance();

        // Simultaneous events
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h0AA, 1'b0); settle(); advance();
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        cyc_idle(3'b010);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h3FF, 1'b1); settle(); advance();
        idle(3'b000); settle();
        check_eq("si_popped", in_svc, 3'b000);
        check_eq("si_epc", bus.epc, 10'h000);
        check_eq("si_pend_kept", pending, 3'b010);
        advance();
        drive(3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("si_setclr", ie, 1'b0);
        advance();
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        drive(3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h155, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("si_rise_ack", pending, 3'b010);
        check_eq("si_rise_svc", in_svc, 3'b010);
        advance();

        // Reset mid-service with two nested levels
        drive(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b0); settle(); advance();
        cyc_idle(3'b001);
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 10'h2AB, 1'b0); settle(); advance();
        idle(3'b000); settle();
        check_eq("rs_svc_before", in_svc, 3'b011);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rs_req", bus.irq_req, 1'b0);
        check_eq("rs_epc", bus.epc, 10'h000);
        check_eq("rs_svc", in_svc, 3'b000);
        check_eq("rs_pend", pending, 3'b000);
        check_eq("rs_ie", ie, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 10'h000, 1'b1); settle(); advance();
        idle(3'b000); settle();
        check_eq("rs_eret_ie", ie, 1'b0);
        check_eq("rs_eret_epc", bus.epc, 10'h000);
        advance();

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            drive(3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 19) == 0),
                  3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 5) == 0));
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
